crc5_r: RTL

CRC5_R -- requirements
Module: crc5_r

---
 rtl/crc5_r_pkg.sv | 33 +++
 rtl/crc5_chk.sv | 32 +++
 rtl/crc5_r.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/crc5_r_pkg.sv
// Shared definitions for the token/handshake receive decoder: PID codes,
// decoder FSM states and CRC5 generator constants.
package crc5_r_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    // x^5 + x^2 + 1 (x^5 term implicit), all-ones seed
    localparam logic [4:0] CRC5_POLY = 5'b00101;
    localparam logic [4:0] CRC5_SEED = 5'b11111;

    typedef enum logic [1:0] {
        IDLE,
        TOK1,
        TOK2,
        DROP
    } state_t;

    function automatic logic is_token(input logic [3:0] pid);
        return (pid == PID_OUT) || (pid == PID_IN) ||
               (pid == PID_SOF) || (pid == PID_SETUP);
    endfunction

    function automatic logic is_hs(input logic [3:0] pid);
        return (pid == PID_ACK) || (pid == PID_NAK) || (pid == PID_STALL);
    endfunction

endpackage

// File: rtl/crc5_chk.sv
// Combinational CRC5 over the 11 token bits (addr[0] first, endp[3] last)
// and comparison against the received 5-bit CRC field.
module crc5_chk
    import crc5_r_pkg::*;
(
    input  logic [10:0] data,
    input  logic [4:0]  field,
    output logic        match
);

    logic [4:0] rem;
    logic [4:0] field_exp;
    logic       fb;

    // Serial LFSR unrolled over the 11 bits, then complement and bit-reverse
    always_comb begin
        rem = CRC5_SEED;
        fb  = 1'b0;
        for (int unsigned i = 0; i < 11; i++) begin
            fb  = rem[4] ^ data[i];
            rem = {rem[3:0], 1'b0};
            if (fb) begin
                rem = rem ^ CRC5_POLY;
            end
        end
        for (int unsigned i = 0; i < 5; i++) begin
            field_exp[i] = ~rem[4-i];
        end
        match = (field_exp == field);
    end

endmodule

// File: rtl/crc5_r.sv
// Receive-side decoder for token and handshake packets: validates PID,
// length and CRC5, and presents decoded fields through a valid/ready register.
module crc5_r
    import crc5_r_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_sop,
    input  logic       rx_eop,
    output logic [3:0] rx_pid,
    output logic [6:0] rx_addr,
    output logic [3:0] rx_endp,
    output logic       rx_is_hs,
    output logic       rx_pkt_valid,
    input  logic       rx_pkt_ready,
    output logic       pid_err,
    output logic       crc_err,
    output logic       len_err,
    output logic       ovf_err
);

    state_t     state, state_nx;
    logic [3:0] pid_q;
    logic [6:0] addr_q;
    logic       endp0_q;

    logic       pid_ok, crc_ok;
    logic       pid_e, crc_e, len_e;
    logic       done, done_hs;
    logic [3:0] out_pid;
    logic [6:0] out_addr;
    logic [3:0] out_endp;

    assign pid_ok = (rx_data[7:4] == ~rx_data[3:0]);

    crc5_chk u_chk (
        .data  ({rx_data[2:0], endp0_q, addr_q}),
        .field (rx_data[7:3]),
        .match (crc_ok)
    );

    // Next-state and error/completion decode for the byte on rx_data
    always_comb begin
        state_nx = state;
        pid_e    = 1'b0;
        crc_e    = 1'b0;
        len_e    = 1'b0;
        done     = 1'b0;
        done_hs  = 1'b0;
        if (rx_valid) begin
            if (rx_sop) begin
                // A start byte outside IDLE aborts the packet in progress
                len_e = (state != IDLE);
                if (!pid_ok) begin
                    pid_e    = 1'b1;
                    state_nx = rx_eop ? IDLE : DROP;
                end else if (is_hs(rx_data[3:0])) begin
                    if (rx_eop) begin
                        done     = 1'b1;
                        done_hs  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        len_e    = 1'b1;
                        state_nx = DROP;
                    end
                end else if (is_token(rx_data[3:0])) begin
                    // A token that ends on its PID byte is too short
                    if (rx_eop) begin
                        len_e    = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = TOK1;
                    end
                end else begin
                    state_nx = rx_eop ? IDLE : DROP;
                end
            end else begin
                case (state)
                    IDLE: state_nx = IDLE;
                    TOK1: begin
                        if (rx_eop) begin
                            len_e    = 1'b1;
                            state_nx = IDLE;
                        end else begin
                            state_nx = TOK2;
                        end
                    end
                    TOK2: begin
                        if (!rx_eop) begin
                            len_e    = 1'b1;
                            state_nx = DROP;
                        end else begin
                            done     = crc_ok;
                            crc_e    = ~crc_ok;
                            state_nx = IDLE;
                        end
                    end
                    DROP: state_nx = rx_eop ? IDLE : DROP;
                    default: state_nx = IDLE;
                endcase
            end
        end
    end

    // Fields for a completing packet; handshakes carry no address/endpoint
    always_comb begin
        out_pid  = done_hs ? rx_data[3:0] : pid_q;
        out_addr = done_hs ? '0 : addr_q;
        out_endp = done_hs ? '0 : {rx_data[2:0], endp0_q};
    end

    // FSM state, token field capture, output register and error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pid_q        <= '0;
            addr_q       <= '0;
            endp0_q      <= 1'b0;
            rx_pid       <= '0;
            rx_addr      <= '0;
            rx_endp      <= '0;
            rx_is_hs     <= 1'b0;
            rx_pkt_valid <= 1'b0;
            pid_err      <= 1'b0;
            crc_err      <= 1'b0;
            len_err      <= 1'b0;
            ovf_err      <= 1'b0;
        end else begin
            state   <= state_nx;
            pid_err <= pid_e;
            crc_err <= crc_e;
            len_err <= len_e;
            ovf_err <= 1'b0;
            if (rx_valid && rx_sop) begin
                pid_q <= rx_data[3:0];
            end
            if (rx_valid && !rx_sop && state == TOK1) begin
                addr_q  <= rx_data[6:0];
                endp0_q <= rx_data[7];
            end
            if (done && (!rx_pkt_valid || rx_pkt_ready)) begin
                rx_pid       <= out_pid;
                rx_addr      <= out_addr;
                rx_endp      <= out_endp;
                rx_is_hs     <= done_hs;
                rx_pkt_valid <= 1'b1;
            end else if (done) begin
                ovf_err <= 1'b1;
            end else if (rx_pkt_ready) begin
                rx_pkt_valid <= 1'b0;
            end
        end
    end

endmodule
